keypad_capture: RTL and testbench

Sits between the keypad pins, the row scanner and the display driver. It synchronizes the raw active-low column inputs and produces the scanner's `key_pressed` input. It then consumes the scanner's `enable` pulse and `{rows, columns}` code, debounces the press, and decodes it to a hex digit. Each accepted press is shifted into a two-digit history: exactly one capture per physical press, with release also debounced.

---
 rtl/keypad_capture.sv | 179 +++++++++++++++++
 tb/tb_keypad_capture.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_capture.sv
// keypad_capture: column synchronizer, press/release debounce and hex decode
// of scanner codes into a two-digit key history.
module keypad_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columns_raw,
    input  logic       enable,
    input  logic [7:0] total_val,
    output logic [3:0] columns_sync,
    output logic       key_pressed,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic       new_key
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       cand;
    logic [7:0]       cand_next;
    logic [3:0]       columns_meta;
    logic             capture_c;
    logic             load_c;
    logic             match_c;
    logic             row_ok_c;
    logic             col_ok_c;
    logic [1:0]       row_idx_c;
    logic [1:0]       col_idx_c;
    logic [3:0]       digit_c;

    // Two-flop synchronizer on the asynchronous keypad columns (idle = all high)
    always_ff @(posedge clk) begin
        if (!reset) begin
            columns_meta <= 4'b1111;
            columns_sync <= 4'b1111;
        end else begin
            columns_meta <= columns_raw;
            columns_sync <= columns_meta;
        end
    end

    assign key_pressed = (columns_sync != 4'b1111);

    // FSM state register with debounce counter and latched candidate code
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= 8'h00;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    // Next-state logic; the counter restarts on every state change
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        capture_c  = 1'b0;
        match_c    = key_pressed && (total_val == cand);
        case (state)
            IDLE: begin
                if (enable) begin
                    cand_next  = total_val;
                    cnt_next   = '0;
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (match_c && (cnt == CNT_LAST)) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    capture_c  = 1'b1;
                end else if (match_c) begin
                    cnt_next = cnt + CNT_W'(1);
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            HELD: begin
                if (!key_pressed) begin
                    state_next = RELEASE;
                    cnt_next   = '0;
                end
            end
            RELEASE: begin
                if (key_pressed) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode: map the candidate code to a hex digit and gate the capture
    always_comb begin
        row_idx_c = 2'd0;
        col_idx_c = 2'd0;
        row_ok_c  = 1'b0;
        col_ok_c  = 1'b0;
        digit_c   = 4'h0;
        case (cand[7:4])
            4'b1000: begin row_idx_c = 2'd0; row_ok_c = 1'b1; end
            4'b0100: begin row_idx_c = 2'd1; row_ok_c = 1'b1; end
            4'b0010: begin row_idx_c = 2'd2; row_ok_c = 1'b1; end
            4'b0001: begin row_idx_c = 2'd3; row_ok_c = 1'b1; end
            default: row_ok_c = 1'b0;
        endcase
        case (cand[3:0])
            4'b0111: begin col_idx_c = 2'd0; col_ok_c = 1'b1; end
            4'b1011: begin col_idx_c = 2'd1; col_ok_c = 1'b1; end
            4'b1101: begin col_idx_c = 2'd2; col_ok_c = 1'b1; end
            4'b1110: begin col_idx_c = 2'd3; col_ok_c = 1'b1; end
            default: col_ok_c = 1'b0;
        endcase
        case ({row_idx_c, col_idx_c})
            4'h0: digit_c = 4'h1;
            4'h1: digit_c = 4'h2;
            4'h2: digit_c = 4'h3;
            4'h3: digit_c = 4'hA;
            4'h4: digit_c = 4'h4;
            4'h5: digit_c = 4'h5;
            4'h6: digit_c = 4'h6;
            4'h7: digit_c = 4'hB;
            4'h8: digit_c = 4'h7;
            4'h9: digit_c = 4'h8;
            4'hA: digit_c = 4'h9;
            4'hB: digit_c = 4'hC;
            4'hC: digit_c = 4'hE;
            4'hD: digit_c = 4'h0;
            4'hE: digit_c = 4'hF;
            4'hF: digit_c = 4'hD;
            default: digit_c = 4'h0;
        endcase
        load_c = capture_c && row_ok_c && col_ok_c;
    end

    // Registered digit history and single-cycle new_key pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit0  <= 4'h0;
            digit1  <= 4'h0;
            new_key <= 1'b0;
        end else begin
            new_key <= load_c;
            if (load_c) begin
                digit1 <= digit0;
                digit0 <= digit_c;
            end
        end
    end

endmodule

// File: tb/tb_keypad_capture.sv
// tb_keypad_capture: randomized, self-checking bench for keypad_capture.
module tb_keypad_capture;

    localparam int unsigned D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] columns_raw;
    logic       enable;
    logic [7:0] total_val;
    logic [3:0] columns_sync;
    logic       key_pressed;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic       new_key;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference history of accepted keys
    logic [3:0] m_d0 = 4'h0;
    logic [3:0] m_d1 = 4'h0;

    // Keypad legend, row-major, columns left to right
    logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

    keypad_capture #(.DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .columns_raw  (columns_raw),
        .enable       (enable),
        .total_val    (total_val),
        .columns_sync (columns_sync),
        .key_pressed  (key_pressed),
        .digit0       (digit0),
        .digit1       (digit1),
        .new_key      (new_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {valid, digit}: valid needs exactly one row high and one column low
    function automatic logic [4:0] model_decode(input logic [7:0] code);
        int rc = 0;
        int cc = 0;
        int r  = 0;
        int c  = 0;
        for (int i = 0; i < 4; i++) begin
            if (code[7-i]) begin rc++; r = i; end
            if (!code[3-i]) begin cc++; c = i; end
        end
        return {(rc == 1) && (cc == 1), key_map[r*4 + c]};
    endfunction

    function automatic void model_push(input logic [7:0] code);
        logic [4:0] d;
        d = model_decode(code);
        if (d[4]) begin
            m_d1 = m_d0;
            m_d0 = d[3:0];
        end
    endfunction

    task automatic check_digits(input string name);
        n_checks++;
        if (digit0 !== m_d0 || digit1 !== m_d1) begin
            n_fail++;
            $display("FAIL %s digits: got d0=%h d1=%h expected d0=%h d1=%h",
                     name, digit0, digit1, m_d0, m_d1);
        end
    endtask

    // Release the key long enough for any release debounce to finish
    task automatic release_key();
        columns_raw = 4'hF;
        repeat (D + 8) tick();
    endtask

    // Hold code, pulse enable once, expect new_key exactly at D+1 cycles if valid
    task automatic press_and_check(input logic [7:0] code, input string name);
        logic [4:0] d;
        logic       exp;
        d = model_decode(code);
        total_val   = code;
        columns_raw = code[3:0];
        repeat (3) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            exp = d[4] && (t == int'(D) + 1);
            n_checks++;
            if (new_key !== exp) begin
                n_fail++;
                $display("FAIL %s new_key t=%0d: got %b expected %b", name, t, new_key, exp);
            end
            tick();
        end
        model_push(code);
        check_digits(name);
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        int pulses = 0;
        for (int t = 0; t < cycles; t++) begin
            tick();
            if (new_key === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL %s new_key pulses: got %0d expected 0", name, pulses);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        enable      = 1'($urandom);
        total_val   = 8'($urandom);
        columns_raw = 4'($urandom);
        repeat (2) tick();
        n_checks++;
        if (digit0 !== 4'h0 || digit1 !== 4'h0 || new_key !== 1'b0 ||
            columns_sync !== 4'b1111 || key_pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got d0=%h d1=%h nk=%b sync=%b kp=%b expected 0 0 0 1111 0",
                     digit0, digit1, new_key, columns_sync, key_pressed);
        end
        enable      = 1'b0;
        columns_raw = 4'hF;
        tick();
        reset = 1'b1;
        repeat (3) tick();
        m_d0 = 4'h0;
        m_d1 = 4'h0;
    endtask

    task automatic test_sync_latency();
        columns_raw = 4'b1011;
        tick();
        n_checks++;
        if (key_pressed !== 1'b0) begin
            n_fail++;
            $display("FAIL sync_1edge key_pressed: got %b expected 0", key_pressed);
        end
        tick();
        n_checks++;
        if (key_pressed !== 1'b1 || columns_sync !== 4'b1011) begin
            n_fail++;
            $display("FAIL sync_2edge: got kp=%b sync=%b expected 1 1011", key_pressed, columns_sync);
        end
        release_key();
    endtask

    task automatic test_clean_press();
        press_and_check(8'b1000_0111, "clean_1");
        release_key();
        press_and_check(8'b0001_1011, "clean_0");
        release_key();
    endtask

    task automatic test_bounce_count();
        logic [7:0] code;
        code        = 8'b0010_1101;
        total_val   = code;
        columns_raw = code[3:0];
        repeat (3) tick();
        enable = 1'b1;
        tick();
        enable      = 1'b0;
        columns_raw = 4'hF;
        tick();
        columns_raw = code[3:0];
        expect_quiet(12, "bounce_abort");
        check_digits("bounce_abort");
        press_and_check(code, "bounce_retry");
        release_key();
    endtask

    task automatic test_held_key();
        logic [7:0] code;
        int pulses = 0;
        int first  = -1;
        code        = {4'b0100, 4'b1110};
        total_val   = code;
        columns_raw = code[3:0];
        repeat (3) tick();
        for (int c = 0; c < 60; c++) begin
            enable = (c < 50) && (c % 3 == 0);
            tick();
            if (new_key === 1'b1) begin
                pulses++;
                if (first < 0) first = c + 1;
            end
        end
        enable = 1'b0;
        n_checks++;
        if (pulses != 1 || first != int'(D) + 1) begin
            n_fail++;
            $display("FAIL held_key: got pulses=%0d first=%0d expected 1 %0d", pulses, first, D + 1);
        end
        model_push(code);
        check_digits("held_key");
        release_key();
    endtask

    // Drop key_pressed for n cycles, then re-press with a fresh code and pulse enable
    task automatic release_then_repress(input int zeros, input logic exp_capture, input string name);
        logic [7:0] code;
        code        = 8'b1000_1011;
        columns_raw = 4'hF;
        repeat (zeros) tick();
        total_val   = code;
        columns_raw = code[3:0];
        repeat (3) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        if (exp_capture) begin
            for (int t = 1; t <= 12; t++) begin
                n_checks++;
                if (new_key !== (t == int'(D) + 1)) begin
                    n_fail++;
                    $display("FAIL %s new_key t=%0d: got %b expected %b", name, t, new_key, t == int'(D) + 1);
                end
                tick();
            end
            model_push(code);
        end else begin
            expect_quiet(12, name);
        end
        check_digits(name);
    endtask

    task automatic test_release_bounce();
        logic [3:0] held;
        press_and_check(8'b0100_0111, "rel_setup");
        held = 4'b0111;
        // key_pressed pattern 0,0,1,0,0,0 then held again
        columns_raw = 4'hF; tick(); tick();
        columns_raw = held; tick();
        columns_raw = 4'hF; tick(); tick(); tick();
        columns_raw = held;
        total_val   = 8'b0100_1011;
        repeat (3) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        expect_quiet(12, "rel_bounce_ignored");
        check_digits("rel_bounce_ignored");
        // D consecutive zeros is one short of finishing the release
        columns_raw = held;
        total_val   = 8'b0100_0111;
        repeat (3) tick();
        release_then_repress(int'(D), 1'b0, "rel_short");
        // D+1 zeros: the HELD cycle that sees the drop plus D counted cycles
        release_then_repress(int'(D) + 1, 1'b1, "rel_exact");
        release_key();
    endtask

    task automatic test_invalid();
        logic [7:0] code;
        code = 8'b0100_0011;
        press_and_check(code, "invalid_two_col");
        total_val = 8'b0100_1011;
        repeat (2) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        expect_quiet(12, "invalid_consumed");
        check_digits("invalid_consumed");
        release_key();
    endtask

    task automatic test_reset_mid();
        logic [7:0] code;
        press_and_check(8'b0001_0111, "pre_reset");
        release_key();
        code        = 8'b0010_0111;
        total_val   = code;
        columns_raw = code[3:0];
        repeat (3) tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (digit0 !== 4'h0 || digit1 !== 4'h0 || new_key !== 1'b0 || columns_sync !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_mid: got d0=%h d1=%h nk=%b sync=%b expected 0 0 0 1111",
                     digit0, digit1, new_key, columns_sync);
        end
        m_d0  = 4'h0;
        m_d1  = 4'h0;
        reset = 1'b1;
        expect_quiet(8, "reset_mid_quiet");
        press_and_check(code, "after_reset_held");
        release_key();
    endtask

    task automatic test_random();
        logic [3:0] rows;
        logic [3:0] cols;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(3) != 0) rows = 4'b0001 << $urandom_range(3);
            else                        rows = 4'($urandom_range(15, 1));
            if ($urandom_range(3) != 0) cols = ~(4'b0001 << $urandom_range(3));
            else                        cols = 4'($urandom_range(14, 0));
            press_and_check({rows, cols}, "random");
            release_key();
        end
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        total_val   = 8'h00;
        columns_raw = 4'hF;
        test_reset();
        test_sync_latency();
        test_clean_press();
        test_bounce_count();
        test_held_key();
        test_release_bounce();
        test_invalid();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
